// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, imem req/ack interface and {inst, pc} buffer feeding decode.
// Build option FETCH_PREFETCH_EN selects a 2-entry prefetch buffer; default is 1 entry.
module fetch_unit #(
   parameter logic [29:0] RESET_PC = 30'h0000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [29:0] redirect_pc,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [29:0] inst_pc
);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned   CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [29:0]   fpc_q, fpc_d;
   logic [CW-1:0] count_q, count_d, wr_idx;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   inst_d [DEPTH];
   logic [29:0]   pc_q   [DEPTH];
   logic [29:0]   pc_d   [DEPTH];
   logic          push, pop;

   assign imem_req   = !rst && (count_q < DEPTH_C);
   assign imem_addr  = fpc_q;
   assign inst_valid = (count_q != '0);
   assign inst       = inst_q[0];
   assign inst_pc    = pc_q[0];
   assign push       = imem_req && imem_ack && !redirect;
   assign pop        = inst_valid && inst_ready && !redirect;

   // Head always sits in entry 0: a pop shifts entries down, a push lands just past the survivors.
   always_comb begin
      fpc_d   = fpc_q;
      count_d = count_q;
      wr_idx  = count_q - CW'(pop);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         inst_d[i] = inst_q[i];
         pc_d[i]   = pc_q[i];
      end
      if (redirect) begin
         fpc_d   = redirect_pc;
         count_d = '0;
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               inst_d[i] = inst_q[i + 1];
               pc_d[i]   = pc_q[i + 1];
            end
         end
         if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (wr_idx == CW'(i)) begin
                  inst_d[i] = imem_rdata;
                  pc_d[i]   = fpc_q;
               end
            end
            fpc_d = fpc_q + 30'd1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q   <= RESET_PC;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         fpc_q   <= fpc_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            inst_q[i] <= inst_d[i];
            pc_q[i]   <= pc_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases queue expected PCs, a monitor checks accepted beats.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, redirect, imem_ack, inst_ready;
   logic [29:0] redirect_pc;
   logic        imem_req, inst_valid;
   logic [29:0] imem_addr, inst_pc;
   logic [31:0] imem_rdata, inst;

   int checks   = 0;
   int failures = 0;
   int accepts  = 0;
   int acks     = 0;
   int a0, b0;
   logic [29:0] exp_q [$];

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {2'b01, a} ^ 32'h3C3C_3C3C;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_unit #(.RESET_PC(30'h10)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic sb_fill(input logic [29:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 30'(i));
   endtask

   // Monitor: samples just before each rising edge, once inputs for that edge are settled.
   always begin
      @(negedge clk);
      #4;
      if (rst === 1'b0 && redirect === 1'b0) begin
         if (imem_req && imem_ack) acks++;
         if (inst_valid && inst_ready) begin
            accepts++;
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_pop", {2'b00, inst_pc}, 32'hFFFF_FFFF);
            end else begin
               logic [29:0] e;
               e = exp_q.pop_front();
               chk("sb_pc", {2'b00, inst_pc}, {2'b00, e});
               chk("sb_inst", inst, mem_word(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b1; inst_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 32'h10);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_pc", inst_pc, 0);

      // Throughput from reset release
      @(negedge clk);
      rst = 1'b0;
      sb_fill(30'h10, 16);
      b0 = accepts;
      #1;
      chk("rel_req", imem_req, 1);
      chk("rel_addr", imem_addr, 32'h10);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         #1;
         chk("tput_valid", inst_valid, (DEPTH == 2) ? 1 : ((k % 2 == 1) ? 1 : 0));
      end
      chk("tput_accepts", accepts - b0, (DEPTH == 2) ? 7 : 4);

      // Backpressure with decode stalled
      redirect = 1'b1; redirect_pc = 30'h40; inst_ready = 1'b0; imem_ack = 1'b1;
      sb_fill(30'h40, 16);
      a0 = acks;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("bp_valid0", inst_valid, 0);
      chk("bp_addr0", imem_addr, 32'h40);
      chk("bp_req0", imem_req, 1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("bp_req_full", imem_req, 0);
      chk("bp_valid", inst_valid, 1);
      chk("bp_head", {2'b00, inst_pc}, 32'h40);
      @(negedge clk);
      #1;
      chk("bp_req_hold", imem_req, 0);
      @(negedge clk);
      #1;
      chk("bp_acks", acks - a0, DEPTH);
      inst_ready = 1'b1;
      b0 = accepts;
      repeat (6) @(negedge clk);
      #1;
      chk("bp_drain", accepts - b0, (DEPTH == 2) ? 6 : 3);

      // Redirect coincident with an ack of 0x13
      redirect = 1'b1; redirect_pc = 30'h12; inst_ready = 1'b0; imem_ack = 1'b1;
      sb_fill(30'h12, 1);
      @(negedge clk);
      redirect = 1'b0;
      @(negedge clk);
      #1;
      chk("rd_valid", inst_valid, 1);
      chk("rd_head", {2'b00, inst_pc}, 32'h12);
`ifndef FETCH_PREFETCH_EN
      inst_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rd_empty", inst_valid, 0);
`endif
      chk("rd_addr13", imem_addr, 32'h13);
      chk("rd_req13", imem_req, 1);
      redirect = 1'b1; redirect_pc = 30'h200; inst_ready = 1'b1;
      sb_fill(30'h200, 16);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("rd_flush_valid", inst_valid, 0);
      chk("rd_new_addr", imem_addr, 32'h200);
      @(negedge clk);
      #1;
      chk("rd_new_valid", inst_valid, 1);
      chk("rd_new_pc", {2'b00, inst_pc}, 32'h200);

      // PC wrap at the top of the 30-bit space
      redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF;
      sb_fill(30'h3FFF_FFFF, 16);
      b0 = accepts;
      @(negedge clk);
      redirect = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      chk("wrap_accepts", accepts - b0, (DEPTH == 2) ? 6 : 3);

      // Reset mid-fetch with ack and redirect in the same cycle
      rst = 1'b1; redirect = 1'b1; redirect_pc = 30'h80; imem_ack = 1'b1;
      exp_q.delete();
      #1;
      chk("mr_req_in_rst", imem_req, 0);
      @(negedge clk);
      #1;
      chk("mr_addr", imem_addr, 32'h10);
      chk("mr_valid", inst_valid, 0);
      chk("mr_inst", inst, 0);
      chk("mr_pc", inst_pc, 0);
      rst = 1'b0; redirect = 1'b0;
      sb_fill(30'h10, 16);
      #1;
      chk("mr_rel_req", imem_req, 1);
      chk("mr_rel_addr", imem_addr, 32'h10);
      @(negedge clk);
      #1;
      chk("mr_first_valid", inst_valid, 1);
      chk("mr_first_pc", {2'b00, inst_pc}, 32'h10);

      // Delayed ack, then spurious acks while the buffer is full
      redirect = 1'b1; redirect_pc = 30'h300; imem_ack = 1'b0;
      sb_fill(30'h300, 2);
      @(negedge clk);
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("dly_addr", imem_addr, 32'h300);
         chk("dly_req", imem_req, 1);
      end
      @(negedge clk);
      inst_ready = 1'b0; imem_ack = 1'b1;
      b0 = accepts;
      #1;
      chk("dly_addr_ack", imem_addr, 32'h300);
      chk("dly_valid_pre", inst_valid, 0);
      @(negedge clk);
      #1;
      chk("dly_valid", inst_valid, 1);
      chk("dly_pc", {2'b00, inst_pc}, 32'h300);
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      chk("sp_req0", imem_req, 0);
      @(negedge clk);
      imem_ack = 1'b1;
      #1;
      chk("sp_req1", imem_req, 0);
      @(negedge clk);
      imem_ack = 1'b0; inst_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("sp_empty", inst_valid, 0);
      chk("sp_accepts", accepts - b0, DEPTH);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage upstream of the next-address logic. Holds the fetch PC, a 30-bit word address, and issues word reads to instruction memory over a req/ack handshake. Buffers the returned words and hands {instruction, PC} to decode over a valid/ready handshake. The next-address stage consumes `inst_pc` as its PC input. When a taken control transfer resolves, it drives its NextPC back into this block as a redirect.

## Interface
- `RESET_PC`, default 30'h0000000: fetch PC loaded on reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `redirect`  in  1: load `redirect_pc` into the fetch PC and flush the buffer.
- `redirect_pc`  in  30: target word address (NextPC).
- `imem_req`  out  1: read request.
- `imem_addr`  out  30: word address of the request.
- `imem_ack`  in  1: request accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: instruction word.
- `inst_valid`  out  1: buffer head holds an instruction.
- `inst_ready`  in  1: decode accepts the head this cycle.
- `inst`  out  32: head instruction.
- `inst_pc`  out  30: word address of the head instruction.

## Operation
- State:
  - `fpc` (30 b): next address to fetch.
  - FIFO of {inst, pc} entries, depth DEPTH.
  - `count`, from 0 to DEPTH.
- Memory side:
  - `imem_req` = !rst && (count < DEPTH).
  - `imem_addr` = `fpc`.
  - At most one request is in flight per cycle.
  - While `imem_req` is high and `imem_ack` is low, `imem_addr` stays stable. The one exception is a redirect edge, which retargets the request.
- Ack handling:
  - An ack with `imem_req` high and `redirect` low pushes {`imem_rdata`, `fpc`} to the FIFO tail.
  - On the same edge, `fpc` <= `fpc` + 1, modulo 2^30: 30'h3FFFFFFF wraps to 30'h0.
  - An `imem_ack` while `imem_req` is low is ignored.
- Decode side:
  - `inst_valid` = (count != 0).
  - `inst` and `inst_pc` are taken from the FIFO head.
  - A pop occurs on an edge with `inst_valid` && `inst_ready` && !`redirect`.
- Push and pop on the same edge: `count` is unchanged and the FIFO order is preserved.
- Redirect takes priority over everything except reset. On that edge:
  - `count` <= 0.
  - `fpc` <= `redirect_pc`.
  - Any ack on the same edge is discarded.
  - Any pop on the same edge is moot, because the flush empties the FIFO.
- Reset takes priority over redirect. On reset:
  - `fpc` <= `RESET_PC`.
  - `count` <= 0.
  - FIFO storage is cleared to 0.
  - Reset mid-fetch abandons the request; an ack in the reset cycle is ignored.

## Timing
- Reset values:
  - `imem_req` = 0 while `rst` is high.
  - `imem_addr` = `RESET_PC`.
  - `inst_valid` = 0, `inst` = 0, `inst_pc` = 0.
- In the first cycle after `rst` falls, `imem_req` = 1 with `imem_addr` = `RESET_PC`.
- Ack-to-valid latency is 1 cycle. Data acked at edge N is visible at the head after edge N, and there is no combinational bypass.
- Redirect at edge N:
  - In cycle N+1, `imem_addr` = `redirect_pc` and `inst_valid` = 0.
  - The first redirected instruction is valid one cycle after its ack.
- No combinational path exists from `inst_ready` to `imem_req`.
- FIFO full (count = DEPTH): `imem_req` = 0 until a pop.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - DEPTH = 2.
  - Sustains one instruction per cycle when `imem_ack` and `inst_ready` are held high.
- `FETCH_PREFETCH_EN` undefined:
  - DEPTH = 1.
  - `imem_req` is only high while the buffer is empty.
  - Peak throughput is one instruction per 2 cycles.
- All other behaviour is identical in both builds.

## Test plan
- Reset release, `RESET_PC`=30'h10, ack every cycle, `inst_ready`=1:
  - Valid PCs are 10, 11, 12, … on consecutive cycles with `FETCH_PREFETCH_EN`.
  - Without the macro, the same PCs appear every other cycle.
- Backpressure: hold `inst_ready`=0 after the first word.
  - With `FETCH_PREFETCH_EN`, `imem_req` drops after 2 acks.
  - Without the macro, it drops after 1 ack.
  - On release, instructions drain in order with no loss or duplication.
- Redirect to 30'h200 in the same cycle as an ack of addr 30'h13 and with head valid:
  - The acked word is discarded.
  - `inst_valid` = 0 in the next cycle and `imem_addr` = 30'h200.
  - The next valid `inst_pc` = 30'h200.
- Wrap: redirect to 30'h3FFFFFFF with acks every cycle → valid PCs are 3FFFFFFF, then 0, then 1.
- `rst` asserted while `imem_req` is high with ack and redirect in the same cycle:
  - All outputs return to reset values.
  - After release, the first address is `RESET_PC`.
- Ack delayed 3 cycles:
  - `imem_addr` stays stable throughout.
  - Spurious `imem_ack` pulses while `imem_req`=0 push nothing.
